inst_fetch_unit: RTL and testbench

//  Program-counter and fetch-control stage directly upstream of the instruction ROM.

---
 rtl/inst_fetch_unit_pkg.sv | 27 ++
 rtl/fetch_hold_buf.sv | 33 +++
 rtl/inst_fetch_unit.sv | 107 ++++++++++
 tb/tb_inst_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared constants and types for the instruction fetch stage
package inst_fetch_unit_pkg;

  // Address fetched first after reset and the sequential byte step
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR_DEFAULT  = 32'd4;

  // Instruction word presented when nothing meaningful is on the output
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Width of one {instruction, pc} entry in the holding buffer
  localparam int unsigned PKT_W = 64;

  // Effective fetch state, encoded as {hold_v, inflight_v}
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_BAD  = 2'b11
  } fetch_state_e;

  // Map the two valid flags onto the debug state encoding
  function automatic fetch_state_e state_of(input logic hold_v, input logic inflight_v);
    return fetch_state_e'({hold_v, inflight_v});
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - single-entry holding register for a stalled {inst, pc}
module fetch_hold_buf
  import inst_fetch_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [PKT_W-1:0] data_i,
  output logic [PKT_W-1:0] data_o,
  output logic             valid_o
);

  logic [PKT_W-1:0] data_q;
  logic             valid_q;

  // Capture on load, drop on clear; clear wins so a redirect always empties the entry
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC sequencing and fetch control in front of a 1-cycle ROM
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_INCR  = PC_INCR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_v_q, inflight_v_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic             hold_v;
  logic [PKT_W-1:0] hold_data;
  logic             hold_load;
  logic             hold_clear;
  logic             stall;
  logic             issue;
  logic             accept;
  fetch_state_e     state_w;

  // The ROM address is always the next PC to fetch; data returns one cycle later
  assign rom_addr = pc_q;

  // A stalled word parks in the holding buffer and takes priority on the output
  assign {inst_out, pc_out} = hold_v ? hold_data : {rom_data, inflight_pc_q};
  assign inst_valid = (hold_v | inflight_v_q) & ~redirect_valid;

  assign stall  = inst_valid & ~inst_ready;
  assign issue  = ~stall & ~redirect_valid;
  assign accept = inst_valid & inst_ready;

  // Only the first stall cycle moves the in-flight ROM word into the buffer
  assign hold_load  = stall & inflight_v_q & ~hold_v;
  assign hold_clear = redirect_valid | (issue & hold_v);

  fetch_hold_buf u_hold (
    .clk_i   (clock),
    .rst_ni  (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .data_i  ({rom_data, inflight_pc_q}),
    .data_o  (hold_data),
    .valid_o (hold_v)
  );

  // Next-state selection: redirect beats stall beats sequential issue
  always_comb begin
    pc_d          = pc_q;
    inflight_v_d  = inflight_v_q;
    inflight_pc_d = inflight_pc_q;
    misaligned_d  = misaligned_q | (redirect_valid & (|redirect_pc[1:0]));
    fetch_count_d = fetch_count_q + {31'b0, accept};
    if (redirect_valid) begin
      pc_d         = redirect_pc & ~32'h3;
      inflight_v_d = 1'b0;
    end else if (stall) begin
      // pc_q is held, so the word fetched this cycle is refetched after the stall
      inflight_v_d = 1'b0;
    end else begin
      inflight_v_d  = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + PC_INCR;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign misaligned  = misaligned_q;
  assign fetch_count = fetch_count_q;

  // A word is either in flight or held, never both
  assign state_w = state_of(hold_v, inflight_v_q);

  a_state_legal : assert property (@(posedge clock) disable iff (!reset) state_w != ST_BAD);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit with ROM model
module tb_inst_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] rom_addr, rom_data;
  logic [31:0] inst_out, pc_out;
  logic        inst_valid, inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic [31:0] fetch_count;

  logic [31:0] w_rom_addr, w_rom_data, w_inst_out, w_pc_out, w_fetch_count;
  logic        w_inst_valid, w_misaligned;
  logic        w_ready, w_redirect;
  logic [31:0] w_redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_unit dut (
    .clock(clock), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misaligned(misaligned), .fetch_count(fetch_count)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock(clock), .reset(reset), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
    .inst_out(w_inst_out), .pc_out(w_pc_out), .inst_valid(w_inst_valid), .inst_ready(w_ready),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .misaligned(w_misaligned), .fetch_count(w_fetch_count)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    rom_data   <= rom_word(rom_addr);
    w_rom_data <= rom_word(w_rom_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: stream of delivered PCs in program order, bubbles after reset/redirect
  bit          m_known = 0;
  logic [31:0] m_pc;
  int          m_bubble;
  logic [31:0] m_cnt;
  logic        m_mis;
  bit          m_tol;
  bit          m_stalled;

  always @(negedge clock) begin
    bit exp_v, eff_v;
    if (m_known) begin
      exp_v = !redirect_valid && (m_bubble == 0);
      if (!m_tol) check_eq("mon_valid", {31'b0, inst_valid}, {31'b0, exp_v});
      if (inst_valid) begin
        check_eq("mon_pc", pc_out, m_pc);
        check_eq("mon_inst", inst_out, rom_word(m_pc));
      end
      check_eq("mon_misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      check_eq("mon_count", fetch_count, m_cnt);
    end
    if (!reset) begin
      m_known = 1; m_pc = 32'h0; m_bubble = 1; m_cnt = 0; m_mis = 0;
      m_tol = 0; m_stalled = 0;
    end else if (m_known) begin
      if (redirect_valid) begin
        m_pc = redirect_pc & ~32'h3;
        m_bubble = 1;
        m_mis = m_mis | (|redirect_pc[1:0]);
        m_tol = 0; m_stalled = 0;
      end else begin
        eff_v = m_tol ? inst_valid : (m_bubble == 0);
        m_tol = 0;
        if (eff_v && inst_ready) begin
          m_cnt = m_cnt + 1;
          m_pc = m_pc + 4;
          if (m_stalled) m_tol = 1;
          m_stalled = 0;
        end else if (eff_v) begin
          m_stalled = 1;
        end else if (m_bubble > 0) begin
          m_bubble--;
        end
      end
    end
  end

  initial begin
    logic [31:0] c0;
    bit          found;
    reset = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    w_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    repeat (3) tick();
    check_eq("reset_valid", {31'b0, inst_valid}, 32'd0);
    check_eq("reset_rom_addr", rom_addr, 32'h0);
    check_eq("reset_count", fetch_count, 32'h0);

    // T1 first instructions after release, plus wrap instance
    reset = 1'b1;
    tick();
    check_eq("t1_valid0", {31'b0, inst_valid}, 32'd1);
    check_eq("t1_inst0", inst_out, 32'hA000_0000);
    check_eq("t1_pc0", pc_out, 32'h0);
    check_eq("t6_wpc0", w_pc_out, 32'hFFFF_FFF8);
    tick();
    check_eq("t1_inst1", inst_out, 32'hA000_0001);
    check_eq("t1_pc1", pc_out, 32'h4);
    check_eq("t6_wpc1", w_pc_out, 32'hFFFF_FFFC);
    tick();
    check_eq("t1_inst2", inst_out, 32'hA000_0002);
    check_eq("t1_pc2", pc_out, 32'h8);
    check_eq("t6_wpc2", w_pc_out, 32'h0);
    check_eq("t6_winst2", w_inst_out, 32'hA000_0000);
    check_eq("t1_count", fetch_count, 32'd2);

    // T2 stall on pc 8 for three cycles
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2_hold_valid", {31'b0, inst_valid}, 32'd1);
      check_eq("t2_hold_pc", pc_out, 32'h8);
      check_eq("t2_hold_inst", inst_out, 32'hA000_0002);
    end
    inst_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      tick();
      if (inst_valid) found = 1;
    end
    check_eq("t2_resume_seen", {31'b0, found}, 32'd1);
    check_eq("t2_resume_pc", pc_out, 32'hC);
    check_eq("t2_resume_inst", inst_out, 32'hA000_0003);
    check_eq("t2_count", fetch_count, 32'd3);

    // T3 redirect while 0x10 is on the output
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (inst_valid && pc_out == 32'h10) found = 1;
      else tick();
    end
    check_eq("t3_reach_10", {31'b0, found}, 32'd1);
    c0 = fetch_count;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    check_eq("t3_squash", {31'b0, inst_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    check_eq("t3_bubble", {31'b0, inst_valid}, 32'd0);
    tick();
    check_eq("t3_valid", {31'b0, inst_valid}, 32'd1);
    check_eq("t3_pc", pc_out, 32'h40);
    check_eq("t3_inst", inst_out, 32'hA000_0010);
    check_eq("t3_count", fetch_count, c0);

    // T4 redirect while the holding buffer is full
    inst_ready = 1'b0;
    tick();
    tick();
    check_eq("t4_held_pc", pc_out, 32'h40);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    check_eq("t4_bubble", {31'b0, inst_valid}, 32'd0);
    tick();
    check_eq("t4_valid", {31'b0, inst_valid}, 32'd1);
    check_eq("t4_pc", pc_out, 32'h80);
    check_eq("t4_inst", inst_out, 32'hA000_0020);
    check_eq("t4_misaligned", {31'b0, misaligned}, 32'd0);

    // T5 misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h23;
    tick();
    redirect_valid = 1'b0;
    tick();
    check_eq("t5_pc", pc_out, 32'h20);
    check_eq("t5_inst", inst_out, 32'hA000_0008);
    check_eq("t5_misaligned", {31'b0, misaligned}, 32'd1);
    repeat (5) tick();
    check_eq("t5_sticky", {31'b0, misaligned}, 32'd1);

    // Randomised traffic checked by the model
    for (int i = 0; i < 500; i++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
      reset          = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset = 1'b1; redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (3) tick();

    // T6 reset asserted while a word is held
    inst_ready = 1'b0;
    tick();
    tick();
    check_eq("t6_pre_valid", {31'b0, inst_valid}, 32'd1);
    reset = 1'b0;
    tick();
    check_eq("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
    check_eq("t6_rst_count", fetch_count, 32'd0);
    check_eq("t6_rst_mis", {31'b0, misaligned}, 32'd0);
    reset = 1'b1; inst_ready = 1'b1;
    tick();
    check_eq("t6_restart_pc", pc_out, 32'h0);
    check_eq("t6_restart_valid", {31'b0, inst_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
